// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR period meter and the LFSR stage it drives.
//   state_t     : controller FSM state encoding (2-bit)
//   MODE_LOAD   : LFSR mode value for a parallel load of p_in
//   MODE_SHIFT  : LFSR mode value for a shift
//   LFSR_WIDTH  : default LFSR width
package lfsr_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;
  localparam int   LFSR_WIDTH = 4;

endpackage

// File: rtl/period_counter.sv
// Shift counter for one period measurement.
//   clk, reset : clock and asynchronous active-low reset
//   clear      : zero the count (LOAD cycle)
//   enable     : advance the count by one
//   status     : LFSR state word
//   seed_r     : captured seed the status is compared against
//   cnt        : shifts seen since the LFSR was loaded
//   match      : status has returned to the seed after at least one shift
//   at_max     : count has reached MAX_COUNT
module period_counter
  import lfsr_pkg::*;
#(
  parameter int WIDTH     = LFSR_WIDTH,
  parameter int CNT_W     = 5,
  parameter int MAX_COUNT = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] status,
  input  logic [WIDTH-1:0] seed_r,
  output logic [CNT_W-1:0] cnt,
  output logic             match,
  output logic             at_max
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  // In the first RUN cycle the LFSR still holds the freshly loaded seed;
  // that is not a return to the seed, so a zero count never matches.
  assign match  = (cnt != '0) && (status == seed_r);
  assign at_max = (cnt == CNT_W'(MAX_COUNT));

endmodule

// File: rtl/lfsr_period_meter.sv
// Measures the sequence length of an external LFSR stage for a given seed.
// Loads the seed, switches the LFSR to shift, counts shifts until the
// status word returns to the seed and reports that count.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   start   : measurement request, sampled in IDLE only
//   seed    : seed, captured when start is accepted
//   status  : LFSR state fed back from the stage
//   mode    : to LFSR, 0 = load p_in, 1 = shift
//   p_in    : to LFSR, parallel-load value (captured seed)
//   busy    : high in LOAD and RUN
//   done    : one-cycle result-valid pulse
//   period  : measured period, 0 on timeout
//   timeout : no return to the seed within MAX_COUNT shifts
module lfsr_period_meter
  import lfsr_pkg::*;
#(
  parameter int WIDTH     = LFSR_WIDTH,
  parameter int CNT_W     = 5,
  parameter int MAX_COUNT = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] status,
  output logic             mode,
  output logic [WIDTH-1:0] p_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] seed_r;
  logic [CNT_W-1:0] cnt;
  logic             match, at_max;
  logic             clear, enable;

  period_counter #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .MAX_COUNT(MAX_COUNT)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .enable(enable),
    .status(status),
    .seed_r(seed_r),
    .cnt   (cnt),
    .match (match),
    .at_max(at_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Match is tested before the limit so a return to the seed on the
  // very last allowed shift still reports a period.
  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    enable    = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        clear     = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (match || at_max) state_nxt = S_DONE;
        else                 enable    = 1'b1;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_r  <= '0;
      period  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        seed_r  <= seed;
        period  <= '0;
        timeout <= 1'b0;
      end else if (state == S_RUN) begin
        if (match) begin
          period <= cnt;
        end else if (at_max) begin
          period  <= '0;
          timeout <= 1'b1;
        end
      end
    end
  end

  // Shift only while running; every other state keeps the LFSR parked
  // on the captured seed.
  assign mode = (state == S_RUN) ? MODE_SHIFT : MODE_LOAD;
  assign p_in = seed_r;
  assign busy = (state == S_LOAD) || (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_lfsr_period_meter.sv
module tb_lfsr_period_meter;

  localparam int W  = 4;
  localparam int CW = 5;
  localparam int MC = 31;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  seed = '0;
  logic [W-1:0]  status;
  logic          mode, busy, done, timeout;
  logic [W-1:0]  p_in;
  logic [CW-1:0] period;

  // closed-loop LFSR stage (x^4 + x^3 + 1), optionally replaced by a stub
  logic [W-1:0]  lfsr = '0;
  logic          stub_en = 1'b0;
  logic [W-1:0]  stub_val = 4'b0101;
  assign status = stub_en ? stub_val : lfsr;
  always @(posedge clk) lfsr <= (mode == 1'b0) ? p_in : {lfsr[2:0], lfsr[3] ^ lfsr[2]};

  lfsr_period_meter #(.WIDTH(W), .CNT_W(CW), .MAX_COUNT(MC)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed), .status(status),
    .mode(mode), .p_in(p_in), .busy(busy), .done(done), .period(period),
    .timeout(timeout)
  );

  // second instance with MAX_COUNT=15: match and limit coincide for a 15-cycle seed
  logic          start2 = 1'b0;
  logic [W-1:0]  seed2 = 4'b1000;
  logic [W-1:0]  lfsr2 = '0;
  logic          mode2, busy2, done2, timeout2;
  logic [W-1:0]  p_in2;
  logic [CW-1:0] period2;
  always @(posedge clk) lfsr2 <= (mode2 == 1'b0) ? p_in2 : {lfsr2[2:0], lfsr2[3] ^ lfsr2[2]};

  lfsr_period_meter #(.WIDTH(W), .CNT_W(CW), .MAX_COUNT(15)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .seed(seed2), .status(lfsr2),
    .mode(mode2), .p_in(p_in2), .busy(busy2), .done(done2), .period(period2),
    .timeout(timeout2)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int last_done_edge = 0;

  typedef struct {
    int period;
    int tmo;
    int accept;
    bit chained;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: walk the LFSR sequence arithmetically until it revisits the seed
  function automatic int ref_next(input int s);
    return ((s << 1) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
  endfunction

  function automatic int ref_period(input int sd, input bit stub, input int sv, input int maxc);
    int s;
    if (stub) return (sv == sd) ? 1 : 0;
    s = sd;
    for (int k = 1; k <= maxc; k++) begin
      s = ref_next(s);
      if (s == sd) return k;
    end
    return 0;
  endfunction

  // monitor: pop an expectation on every done pulse
  exp_t m_e;
  int   m_acc;
  always @(negedge clk) begin
    if (reset && done) begin
      n_done++;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        m_e   = q.pop_front();
        m_acc = m_e.chained ? last_done_edge + 2 : m_e.accept;
        check("period", int'(period), m_e.period);
        check("timeout", int'(timeout), m_e.tmo);
        check("latency", edges - m_acc, (m_e.period == 0) ? MC + 2 : m_e.period + 2);
      end
      last_done_edge = edges;
    end
  end

  function automatic exp_t mk(input int sd, input bit stub, input int acc, input bit ch);
    exp_t e;
    e.period  = ref_period(sd, stub, int'(stub_val), MC);
    e.tmo     = (e.period == 0) ? 1 : 0;
    e.accept  = acc;
    e.chained = ch;
    return e;
  endfunction

  task automatic run_one(input int sd);
    @(negedge clk);
    seed  = W'(sd);
    start = 1'b1;
    q.push_back(mk(sd, stub_en, edges + 1, 1'b0));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_drain: got %0d pending results expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic wait_done(input string name, input int prev, input int budget);
    int n;
    n = 0;
    while (n_done <= prev && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n_done <= prev) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_wait: got no done expected done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int d0, n2, gap;
    exp_t e;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_mode", int'(mode), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_period", int'(period), 0);
    check("rst_timeout", int'(timeout), 0);
    check("rst_p_in", int'(p_in), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // T2: seed 1000, period 15, LFSR reparked at the seed after DONE
    run_one(4'b1000);
    drain("t2", 60);
    @(posedge clk);
    #1;
    check("t2_status_after_done", int'(status), 4'b1000);
    repeat (3) @(negedge clk);
    check("t2_period_hold", int'(period), 15);

    // T1: reset mid-run aborts with no result
    run_one(4'b0110);
    repeat (6) @(negedge clk);
    d0 = n_done;
    reset = 1'b0;
    #1;
    check("t1_mode", int'(mode), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_done", int'(done), 0);
    check("t1_period", int'(period), 0);
    check("t1_timeout", int'(timeout), 0);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("t1_no_done_after_abort", n_done - d0, 0);

    // T3: all-zero seed locks up, period 1
    run_one(0);
    drain("t3", 20);

    // T4: every nonzero seed back to back with start held
    repeat (2) @(negedge clk);
    d0 = n_done;
    for (int s = 1; s <= 15; s++) q.push_back(mk(s, 1'b0, edges + 1, s != 1));
    seed  = 4'd1;
    start = 1'b1;
    for (int s = 2; s <= 16; s++) begin
      wait_done("t4", n_done, 60);
      if (s <= 15) seed = W'(s);
      else         start = 1'b0;
    end
    drain("t4", 60);
    check("t4_done_count", n_done - d0, 15);

    // T5: stuck status never returns to the seed -> timeout
    repeat (2) @(negedge clk);
    stub_en = 1'b1;
    run_one(4'b1010);
    drain("t5", 80);
    @(negedge clk);
    stub_en = 1'b0;
    repeat (2) @(negedge clk);

    // T6: start pulses and seed changes during RUN are ignored
    run_one(4'b0011);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      seed  = W'($urandom_range(0, 15));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
    end
    drain("t6", 60);
    repeat (3) @(negedge clk);
    check("t6_no_extra_start", int'(busy), 0);

    // randomized seeds with random idle gaps
    for (int i = 0; i < 12; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      run_one($urandom_range(0, 15));
      drain("rand", 60);
    end

    // match on the last allowed shift beats timeout (MAX_COUNT=15 instance)
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n2 = 0;
    while (!done2 && n2 < 40) begin
      @(negedge clk);
      n2++;
    end
    e = mk(4'b1000, 1'b0, 0, 1'b0);
    check("limit_done_seen", int'(done2), 1);
    check("limit_period", int'(period2), e.period);
    check("limit_timeout", int'(timeout2), 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
